three_phase_spwm: RTL and testbench
===================================

THREE_PHASE_SPWM -- requirements
Module: three_phase_spwm

Interface
REQ-001 SHALL have parameter CW, default 10: triangular carrier width in bits; carrier peak is 2^CW-1.
REQ-002 SHALL have parameter DEAD, default 8: dead-time length in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock domain, reset asynchronous and active-low.
REQ-005 SHALL have port en  input  1  modulation enable, synchronous.
REQ-006 SHALL have port mod_a  input  16  phase A modulating sample, unsigned, 0x8000 = zero crossing.
REQ-007 SHALL have port mod_b  input  16  phase B modulating sample, same format.
REQ-008 SHALL have port mod_c  input  16  phase C modulating sample, same format.
REQ-009 SHALL have port gh  output  3  high-side gate drives, bit0=A, bit1=B, bit2=C.
REQ-010 SHALL have port gl  output  3  low-side gate drives, same bit order.
REQ-011 SHALL have port sync  output  1  one-cycle pulse at the carrier valley.

Function
REQ-012 SHALL keep a CW-bit up/down carrier: count up 0 -> 2^CW-1, then down -> 0, then up; each extreme held exactly one cycle; period 2*(2^CW-1) cycles (2046 at CW=10).
REQ-013 SHALL assert sync for one cycle in the cycle the carrier is 0 with direction about to turn up.
REQ-014 SHALL latch the upper CW bits of mod_a/b/c into shadow duty registers only in the cycle sync is asserted; mid-period input changes SHALL have no effect until the next valley.
REQ-015 SHALL compute the raw PWM per phase as (duty > carrier), registered, giving 1 cycle latency from carrier to raw PWM.
REQ-016 SHALL treat duty 0 as raw 0 for the whole period and duty 2^CW-1 as raw 1 except in the single peak cycle.
REQ-017 SHALL run a per-phase dead-time FSM with states LOW_ON, DEAD_TO_H, HIGH_ON, DEAD_TO_L.
REQ-018 In LOW_ON, gl=1, gh=0; on raw=1 -> DEAD_TO_H, load the dead counter with DEAD.
REQ-019 In DEAD_TO_H, gh=gl=0; counter decrements each cycle; at 0 -> HIGH_ON; if raw returns to 0 first -> LOW_ON immediately.
REQ-020 HIGH_ON and DEAD_TO_L SHALL mirror REQ-018/REQ-019 with gh and gl swapped.
REQ-021 SHALL drive gh and gl from registers, never asserting both bits of a phase in the same cycle under any input sequence.
REQ-022 A raw PWM pulse shorter than DEAD cycles SHALL produce no pulse on the opposite switch.
REQ-023 When en=0: carrier held at 0 with direction up, sync=0, all FSMs forced to DEAD_TO_L with gh=gl=0.
REQ-024 On en rising: carrier restarts at 0; sync SHALL pulse in the first enabled cycle so duties load before any comparison.
REQ-025 All three phases SHALL share one carrier and update duties in the same cycle.

Reset
REQ-026 While rst_n=0: gh=0, gl=0, sync=0, carrier=0 direction up, duties=0, FSMs in DEAD_TO_L with counter 0, all asynchronously.
REQ-027 After rst_n release with en=1: LOW_ON reached one cycle later, giving gl=3'b111; no high-side pulse before the first valley.
REQ-028 Reset asserted mid-dead-time or mid-pulse SHALL clear gh and gl within the same cycle, without waiting for a clock edge.

Verification
REQ-029 mod_a=mod_b=mod_c=0x8000, en=1 -> each phase gh high for 1023-DEAD cycles per 2046-cycle period; sync every 2046 cycles.
REQ-030 mod_a=0x0000 -> gh[0] never asserted and gl[0] constant 1 after start-up; mod_b=0xFFFF -> gl[1] asserted only at the peak, with the pulse suppressed by REQ-022.
REQ-031 Any raw edge -> gh and gl both 0 for exactly DEAD=8 cycles before the opposite switch turns on; assert !(gh&gl) on every cycle of every test.
REQ-032 mod_a changed from 0x4000 to 0xC000 mid-period -> duty change visible only after the next sync pulse.
REQ-033 en dropped mid-pulse -> gh=gl=0 on the next edge; en re-raised -> sync in the first enabled cycle and the carrier counts from 0.
REQ-034 rst_n pulsed low during DEAD_TO_H -> outputs 0 immediately; after release, behaviour matches REQ-027.

Source files
------------

// File: rtl/three_phase_spwm.sv
// Three-phase sine PWM: one shared triangle carrier, per-phase compare and dead-time gate drive.
// Latency: carrier -> raw PWM 1 cycle; raw PWM -> gate 1 cycle, plus DEAD cycles on each turn-on.
// Backpressure: none; free-running, modulating samples are sampled only at the carrier valley.
module three_phase_spwm #(
    parameter int CW   = 10,
    parameter int DEAD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] mod_a,
    input  logic [15:0] mod_b,
    input  logic [15:0] mod_c,
    output logic [2:0]  gh,
    output logic [2:0]  gl,
    output logic        sync
);

    localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
    localparam logic [CW-1:0] CONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    DEAD_CNT = 8'(DEAD);

    // Dead-time FSM encoding
    localparam logic [1:0] LOW_ON    = 2'd0;
    localparam logic [1:0] DEAD_TO_H = 2'd1;
    localparam logic [1:0] HIGH_ON   = 2'd2;
    localparam logic [1:0] DEAD_TO_L = 2'd3;

    // Carrier state. 'run' is low in the first enabled cycle so the valley
    // (and its sync pulse) is held for exactly one cycle after enable.
    logic [CW-1:0] carrier;
    logic          dir_up;
    logic          run;
    logic          sync_nxt;

    // Duty path
    logic [CW-1:0] mod_top  [3];
    logic [CW-1:0] duty     [3];
    logic [CW-1:0] duty_new [3];
    logic [2:0]    raw;

    // Dead-time FSMs
    logic [1:0]    st      [3];
    logic [1:0]    st_nxt  [3];
    logic [7:0]    cnt     [3];
    logic [7:0]    cnt_nxt [3];
    logic [2:0]    gh_nxt;
    logic [2:0]    gl_nxt;

    // Only the top CW bits of each sample set the duty; the rest are below resolution.
    logic unused_mod_lsbs;
    assign unused_mod_lsbs = ^{mod_a[15-CW:0], mod_b[15-CW:0], mod_c[15-CW:0]};

    assign mod_top[0] = mod_a[15 -: CW];
    assign mod_top[1] = mod_b[15 -: CW];
    assign mod_top[2] = mod_c[15 -: CW];

    // Sync is registered: it fires in the cycle whose carrier value is the valley.
    always_comb begin
        sync_nxt = 1'b0;
        if (en) begin
            if (!run) begin
                sync_nxt = 1'b1;
            end else if (!dir_up && carrier == CONE) begin
                sync_nxt = 1'b1;
            end
        end
    end

    // Up/down carrier: 0 -> CMAX -> 0, each extreme visited for a single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier <= '0;
            dir_up  <= 1'b1;
            run     <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync <= sync_nxt;
            if (!en) begin
                carrier <= '0;
                dir_up  <= 1'b1;
                run     <= 1'b0;
            end else if (!run) begin
                run <= 1'b1;
            end else if (dir_up) begin
                carrier <= carrier + CONE;
                if (carrier == CMAX - CONE) begin
                    dir_up <= 1'b0;
                end
            end else begin
                carrier <= carrier - CONE;
                if (carrier == CONE) begin
                    dir_up <= 1'b1;
                end
            end
        end
    end

    // In the valley cycle the comparison already uses the freshly loaded duty.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            duty_new[i] = sync ? mod_top[i] : duty[i];
        end
    end

    // Shadow duties load only at the valley; raw PWM is the registered compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                duty[i] <= '0;
            end
            raw <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync) begin
                    duty[i] <= mod_top[i];
                end
                raw[i] <= en && run && (duty_new[i] > carrier);
            end
        end
    end

    // Dead-time next state. The counter is loaded with DEAD on entry to a dead
    // state and the switch turns on as it decrements to zero, so both gates are
    // off for exactly DEAD cycles. A count already at zero (after reset or
    // disable) lets the first raw level take effect immediately.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            if (!en) begin
                st_nxt[i]  = DEAD_TO_L;
                cnt_nxt[i] = '0;
            end else begin
                case (st[i])
                    LOW_ON: begin
                        if (raw[i]) begin
                            st_nxt[i]  = DEAD_TO_H;
                            cnt_nxt[i] = DEAD_CNT;
                        end
                    end
                    DEAD_TO_H: begin
                        if (!raw[i]) begin
                            st_nxt[i]  = LOW_ON;
                            cnt_nxt[i] = '0;
                        end else if (cnt[i] <= 8'd1) begin
                            st_nxt[i]  = HIGH_ON;
                            cnt_nxt[i] = '0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 8'd1;
                        end
                    end
                    HIGH_ON: begin
                        if (!raw[i]) begin
                            st_nxt[i]  = DEAD_TO_L;
                            cnt_nxt[i] = DEAD_CNT;
                        end
                    end
                    default: begin
                        if (raw[i]) begin
                            st_nxt[i]  = HIGH_ON;
                            cnt_nxt[i] = '0;
                        end else if (cnt[i] <= 8'd1) begin
                            st_nxt[i]  = LOW_ON;
                            cnt_nxt[i] = '0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Gate drives decoded from the single next state, so gh and gl of one phase can never overlap.
    always_comb begin
        gh_nxt = '0;
        gl_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            gh_nxt[i] = (st_nxt[i] == HIGH_ON);
            gl_nxt[i] = (st_nxt[i] == LOW_ON);
        end
    end

    // FSM state, dead counters and gate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= DEAD_TO_L;
                cnt[i] <= '0;
            end
            gh <= '0;
            gl <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
            gh <= gh_nxt;
            gl <= gl_nxt;
        end
    end

endmodule

// File: tb/tb_three_phase_spwm.sv
// Bench for three_phase_spwm: behavioural model (triangle formula, run-length dead-time rule) checked every cycle.
// Latency: model is updated on each clock edge; outputs compared on the falling edge.
// Backpressure: none; stimulus is directed sections plus randomized duties and enable drops.
module tb_three_phase_spwm;

    localparam int CW   = 10;
    localparam int DEAD = 8;
    localparam int PK   = (1 << CW) - 1;
    localparam int PER  = 2 * PK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] mod_a = 16'h8000;
    logic [15:0] mod_b = 16'h8000;
    logic [15:0] mod_c = 16'h8000;
    logic [2:0]  gh;
    logic [2:0]  gl;
    logic        sync;

    three_phase_spwm #(.CW(CW), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mod_a (mod_a),
        .mod_b (mod_b),
        .mod_c (mod_c),
        .gh    (gh),
        .gl    (gl),
        .sync  (sync)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k counts cycles since the first enabled cycle (-1 while disabled).
    int       m_k;
    int       m_duty [3];
    bit [2:0] m_raw;
    int       m_run  [3];   // consecutive samples raw has held its current level
    bit [2:0] m_rlast;
    int       m_side [3];   // last conducting switch: 0 none, 1 low, 2 high
    bit [2:0] e_gh;
    bit [2:0] e_gl;
    bit       e_sync;

    function automatic int tri_at(input int k);
        int m;
        m = k % PER;
        return (m <= PK) ? m : PER - m;
    endfunction

    function automatic int mod_sel(input int i);
        logic [15:0] v;
        v = (i == 0) ? mod_a : (i == 1) ? mod_b : mod_c;
        return int'(v >> (16 - CW));
    endfunction

    task automatic model_reset();
        m_k = -1; e_sync = 0; e_gh = '0; e_gl = '0; m_raw = '0; m_rlast = '0;
        for (int i = 0; i < 3; i++) begin
            m_duty[i] = 0; m_run[i] = 0; m_side[i] = 0;
        end
    endtask

    task automatic model_step();
        int kprev;
        bit [2:0] rawcur;
        kprev  = m_k;
        rawcur = m_raw;
        for (int i = 0; i < 3; i++) begin
            if (!en) begin
                e_gh[i] = 0; e_gl[i] = 0; m_side[i] = 0; m_run[i] = 0;
            end else begin
                if (m_run[i] > 0 && rawcur[i] == m_rlast[i]) m_run[i]++;
                else m_run[i] = 1;
                m_rlast[i] = rawcur[i];
                // A switch turns on at once if the opposite one never conducted
                // since the last turn-off; otherwise raw must hold DEAD+1 samples.
                e_gh[i] = rawcur[i] && (m_side[i] != 1 || m_run[i] > DEAD);
                e_gl[i] = !rawcur[i] && (m_side[i] != 2 || m_run[i] > DEAD);
                if (e_gh[i]) m_side[i] = 2;
                if (e_gl[i]) m_side[i] = 1;
            end
            if (kprev >= 0 && (kprev % PER) == 0) m_duty[i] = mod_sel(i);
            m_raw[i] = en && (kprev >= 0) && (m_duty[i] > tri_at(kprev));
        end
        m_k    = !en ? -1 : (kprev < 0 ? 0 : kprev + 1);
        e_sync = en && (m_k >= 0) && ((m_k % PER) == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("cyc_gh", int'(gh), int'(e_gh));
                check("cyc_gl", int'(gl), int'(e_gl));
                check("cyc_sync", int'(sync), int'(e_sync));
                check("cyc_no_overlap", int'(gh & gl), 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running expected done");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    int ghc [3];
    int glc [3];
    int xs;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic measure_period(input int chg_at, input logic [15:0] chg_val);
        for (int i = 0; i < 3; i++) begin
            ghc[i] = 0; glc[i] = 0;
        end
        xs = 0;
        for (int j = 0; j < PER; j++) begin
            if (j == chg_at) mod_a = chg_val;
            for (int i = 0; i < 3; i++) begin
                ghc[i] += int'(gh[i]);
                glc[i] += int'(gl[i]);
            end
            if (j > 0 && sync) xs++;
            cyc();
        end
    endtask

    task automatic check_period(input string name);
        check({name, "_sync_at_period"}, int'(sync), 1);
        check({name, "_sync_extra"}, xs, 0);
    endtask

    task automatic wait_sync(input string name, input int max);
        int n;
        n = 0;
        while (!sync && n < max) begin
            cyc();
            n++;
        end
        check(name, int'(sync), 1);
    endtask

    task automatic wait_bit(input string name, input bit hi_side, input bit val);
        int n;
        n = 0;
        while ((hi_side ? gh[0] : gl[0]) != val && n < 3 * PER) begin
            cyc();
            n++;
        end
        check(name, int'(hi_side ? gh[0] : gl[0]), int'(val));
    endtask

    task automatic dead_gap(input string name, input bit to_hi);
        int n;
        n = 0;
        while (gh[0] == 1'b0 && gl[0] == 1'b0 && n < 64) begin
            cyc();
            n++;
        end
        check({name, "_len"}, n, 8);
        check({name, "_on"}, int'(to_hi ? gh[0] : gl[0]), 1);
    endtask

    function automatic logic [15:0] rand_mod();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(1, 8) << 6);
            3:       return 16'hFFFF - 16'($urandom_range(0, 8) << 6);
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_gh", int'(gh), 0);
        check("reset_gl", int'(gl), 0);
        check("reset_sync", int'(sync), 0);
        chk_on = 1'b1;

        // Release with enable high: low sides on one cycle later, first valley.
        rst_n = 1'b1;
        en    = 1'b1;
        cyc();
        check("start_gl", int'(gl), 7);
        check("start_gh", int'(gh), 0);
        check("start_sync", int'(sync), 1);

        // Half duty: duty 512 gives 1023 raw-high cycles, 1015 after dead time.
        measure_period(-1, 16'h0);
        check_period("half_warm");
        measure_period(-1, 16'h0);
        check_period("half");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("half_gh%0d", i), ghc[i], 1015);
            check($sformatf("half_gl%0d", i), glc[i], 1015);
        end

        // Dead gaps in both directions.
        wait_bit("l2h_gl_on", 1'b0, 1'b1);
        wait_bit("l2h_gl_off", 1'b0, 1'b0);
        dead_gap("dead_l2h", 1'b1);
        wait_bit("h2l_gh_off", 1'b1, 1'b0);
        dead_gap("dead_h2l", 1'b0);

        // Extremes: duty 0 keeps the low side on; full duty suppresses the one-cycle low pulse.
        wait_sync("ext_wait", 2 * PER);
        mod_a = 16'h0000;
        mod_b = 16'hFFFF;
        mod_c = 16'h8000;
        measure_period(-1, 16'h0);
        check_period("ext_warm");
        measure_period(-1, 16'h0);
        check_period("ext");
        check("zero_gh", ghc[0], 0);
        check("zero_gl", glc[0], 2046);
        check("full_gl", glc[1], 0);
        check("full_gh", ghc[1], 2045);

        // Mid-period duty change applies only after the next valley.
        wait_sync("chg_wait", 2 * PER);
        mod_a = 16'h4000;
        measure_period(-1, 16'h0);
        check_period("q_warm");
        measure_period(100, 16'hC000);
        check_period("q_chg");
        check("q_gl_before", glc[0], 1527);
        measure_period(-1, 16'h0);
        check_period("q_after");
        check("q_gl_after", glc[0], 503);

        // Randomized duties with mid-period updates and short enable drops.
        mod_a = rand_mod();
        mod_b = rand_mod();
        mod_c = rand_mod();
        for (int c = 0; c < 5 * PER; c++) begin
            if ($urandom_range(0, 255) == 0) begin
                case ($urandom_range(0, 2))
                    0:       mod_a = rand_mod();
                    1:       mod_b = rand_mod();
                    default: mod_c = rand_mod();
                endcase
            end
            if ($urandom_range(0, 2999) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 20)) cyc();
                en = 1'b1;
            end
            cyc();
        end

        // Enable dropped mid-pulse, then re-raised.
        mod_a = 16'h8000;
        mod_b = 16'h8000;
        mod_c = 16'h8000;
        wait_sync("en_wait1", 2 * PER);
        measure_period(-1, 16'h0);
        repeat (5) cyc();
        en = 1'b0;
        cyc();
        check("endrop_gh", int'(gh), 0);
        check("endrop_gl", int'(gl), 0);
        check("endrop_sync", int'(sync), 0);
        repeat (4) cyc();
        en = 1'b1;
        cyc();
        check("enrise_sync", int'(sync), 1);
        check("enrise_gl", int'(gl), 7);
        measure_period(-1, 16'h0);
        check_period("enrise");

        // Reset asserted inside a low-to-high dead interval.
        wait_bit("rst_gl_on", 1'b0, 1'b1);
        wait_bit("rst_gl_off", 1'b0, 1'b0);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        check("rstmid_gh", int'(gh), 0);
        check("rstmid_gl", int'(gl), 0);
        check("rstmid_sync", int'(sync), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rstrel_gl", int'(gl), 7);
        check("rstrel_gh", int'(gh), 0);
        check("rstrel_sync", int'(sync), 1);
        measure_period(-1, 16'h0);
        check_period("rstrel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
